uart_rx: RTL and testbench

Serial receiver for the processor's UART peripheral. It is the counterpart of the transmit path that drives `uart_s_out`. The block samples the asynchronous `uart_s_in` line and decodes 8-bit frames: LSB first, 1 start bit, optional even parity, 1 stop bit. Decoded bytes go into a small first-word-fall-through FIFO that the processor's load/store path reads. Frame, parity and overrun conditions are reported as sticky error flags.

---
 rtl/uart_rx.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, optional even parity, 1 stop bit.
// Decoded bytes land in a first-word-fall-through FIFO with sticky error flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_s_in,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FIFO_MAX = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic          r_sync1;
    logic          r_rxs;
    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nx;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nx;
    logic          r_par_bad;
    logic          w_par_bad_nx;

    logic          w_tick;
    logic          w_push;
    logic          w_pop;
    logic          w_frame_set;
    logic          w_par_set;
    logic          w_ovr_set;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_frame_err;
    logic          r_parity_err;
    logic          r_overrun;

    assign w_tick = (r_cnt == '0);
    assign w_pop  = rd_en && (r_count != '0);

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= uart_s_in;
            r_rxs   <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_idx     <= w_idx_nx;
            r_shift   <= w_shift_nx;
            r_par_bad <= w_par_bad_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_idx_nx     = r_idx;
        w_shift_nx   = r_shift;
        w_par_bad_nx = r_par_bad;
        w_push       = 1'b0;
        w_frame_set  = 1'b0;
        w_par_set    = 1'b0;
        w_ovr_set    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!r_rxs) begin
                    w_cnt_nx   = HALF_M1;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (!w_tick) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else if (r_rxs) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx     = FULL_M1;
                    w_idx_nx     = '0;
                    w_par_bad_nx = 1'b0;
                    w_state_nx   = S_DATA;
                end
            end
            S_DATA: begin
                if (!w_tick) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_shift_nx = {r_rxs, r_shift[7:1]};
                    w_cnt_nx   = FULL_M1;
                    if (r_idx == 3'd7) begin
                        w_state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (!w_tick) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_par_bad_nx = (^r_shift) ^ r_rxs;
                    w_cnt_nx     = FULL_M1;
                    w_state_nx   = S_STOP;
                end
            end
            S_STOP: begin
                if (!w_tick) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else if (!r_rxs) begin
                    w_frame_set = 1'b1;
                    w_state_nx  = S_WAIT_HIGH;
                end else begin
                    w_state_nx = S_IDLE;
                    if (r_par_bad) begin
                        w_par_set = 1'b1;
                    end else if ((r_count != FIFO_MAX) || w_pop) begin
                        w_push = 1'b1;
                    end else begin
                        w_ovr_set = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (r_rxs) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= r_shift;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A set event in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err  <= w_frame_set | (r_frame_err  & ~err_clr);
            r_parity_err <= w_par_set   | (r_parity_err & ~err_clr);
            r_overrun    <= w_ovr_set   | (r_overrun    & ~err_clr);
        end
    end

    assign rx_data    = r_mem[r_rptr];
    assign rx_valid   = (r_count != '0);
    assign rx_full    = (r_count == FIFO_MAX);
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one no-parity and one even-parity receiver.
// Frames are driven on the falling clock edge, outputs sampled away from posedge.
module tb_uart_rx;

    localparam int C   = 16;
    localparam int LAT = 2 + C / 2 + 9 * C + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s0 = 1'b1;
    logic       s1 = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_full;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    logic [7:0] rx_data_p;
    logic       rx_valid_p;
    logic       rx_full_p;
    logic       frame_err_p;
    logic       parity_err_p;
    logic       overrun_p;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .uart_s_in(s0), .rd_en(rd_en),
        .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_full(rx_full), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun)
    );

    uart_rx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .DEPTH(4)) u_dutp (
        .clk(clk), .rst(rst), .uart_s_in(s1), .rd_en(rd_en),
        .err_clr(err_clr), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
        .rx_full(rx_full_p), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .overrun(overrun_p)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) s0 = v;
        else s1 = v;
    endtask

    // par < 0 means no parity bit; caller must be on a falling edge
    task automatic send(input int sel, input logic [7:0] b,
                        input int par, input logic stop);
        drive(sel, 1'b0);
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            repeat (C) @(negedge clk);
        end
        if (par >= 0) begin
            drive(sel, par[0]);
            repeat (C) @(negedge clk);
        end
        drive(sel, stop);
        repeat (C) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    logic [7:0] exp_q [4];
    logic [7:0] part;
    int n;

    initial begin
        exp_q = '{8'h01, 8'h80, 8'hFF, 8'h00};
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_full", 32'(rx_full), 32'h0);
        check("rst_errs", 32'({frame_err, parity_err, overrun}), 32'h0);

        n = 0;
        fork
            send(0, 8'hA5, -1, 1'b1);
            begin
                while (!rx_valid && n < 400) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        check("latency", 32'(n), 32'(LAT));
        check("a5_data", 32'(rx_data), 32'hA5);
        pop();
        check("a5_pop", 32'(rx_valid), 32'h0);

        for (int i = 0; i < 4; i++) send(0, exp_q[i], -1, 1'b1);
        check("full", 32'(rx_full), 32'h1);
        check("no_ovr_yet", 32'(overrun), 32'h0);
        send(0, 8'h3C, -1, 1'b1);
        check("overrun", 32'(overrun), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fifo%0d", i), 32'(rx_data), 32'(exp_q[i]));
            pop();
        end
        check("fifo_empty", 32'(rx_valid), 32'h0);

        err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'h0);

        s0 = 1'b0;
        repeat (5) @(negedge clk);
        s0 = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_valid", 32'(rx_valid), 32'h0);
        check("glitch_errs", 32'({frame_err, parity_err, overrun}), 32'h0);
        send(0, 8'h5A, -1, 1'b1);
        check("5a_data", 32'(rx_data), 32'h5A);
        check("5a_valid", 32'(rx_valid), 32'h1);
        pop();

        send(0, 8'h33, -1, 1'b0);
        repeat (40 * C) @(negedge clk);
        s0 = 1'b1;
        repeat (3 * C) @(negedge clk);
        check("frame_err", 32'(frame_err), 32'h1);
        check("break_valid", 32'(rx_valid), 32'h0);
        err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        check("frame_clr", 32'(frame_err), 32'h0);

        send(1, 8'h07, 1, 1'b1);
        check("par_ok_valid", 32'(rx_valid_p), 32'h1);
        check("par_ok_data", 32'(rx_data_p), 32'h07);
        check("par_ok_err", 32'(parity_err_p), 32'h0);
        pop();
        send(1, 8'h07, 0, 1'b1);
        check("par_bad_err", 32'(parity_err_p), 32'h1);
        check("par_bad_valid", 32'(rx_valid_p), 32'h0);
        check("par_bad_frm", 32'(frame_err_p), 32'h0);

        send(0, 8'h11, -1, 1'b1);
        send(0, 8'h22, -1, 1'b1);
        check("q2_head", 32'(rx_data), 32'h11);
        part = 8'h5F;
        s0 = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            s0 = part[i];
            repeat (C) @(negedge clk);
        end
        s0 = part[4];
        repeat (C / 2) @(negedge clk);
        rst = 1'b0;
        s0 = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rx_valid), 32'h0);
        check("mid_rst_data", 32'(rx_data), 32'h0);
        check("mid_rst_full", 32'(rx_full), 32'h0);
        check("mid_rst_perr", 32'(parity_err_p), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2 * C) @(negedge clk);
        check("post_rst_valid", 32'(rx_valid), 32'h0);
        send(0, 8'hC3, -1, 1'b1);
        check("c3_data", 32'(rx_data), 32'hC3);
        check("c3_valid", 32'(rx_valid), 32'h1);
        check("c3_errs", 32'({frame_err, parity_err, overrun}), 32'h0);
        pop();
        check("c3_pop", 32'(rx_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
